// File: rtl/soc_arb_wb.sv
// Round-robin Wishbone arbiter: N masters share one slave, with ownership
// held for the whole cycle and an optional no-response timeout.
module soc_arb_wb #(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]     m_dat_i,
    input  logic [MASTERS-1:0]                     m_cyc_i,
    input  logic [MASTERS-1:0]                     m_stb_i,
    input  logic [MASTERS-1:0]                     m_we_i,
    input  logic [MASTERS-1:0][DATA_WIDTH/8-1:0]   m_sel_i,
    input  logic [MASTERS-1:0][2:0]                m_cti_i,
    input  logic [MASTERS-1:0][1:0]                m_bte_i,
    output logic [MASTERS-1:0][DATA_WIDTH-1:0]     m_dat_o,
    output logic [MASTERS-1:0]                     m_ack_o,
    output logic [MASTERS-1:0]                     m_err_o,
    output logic [MASTERS-1:0]                     m_rty_o,
    output logic [ADDR_WIDTH-1:0]                  s_adr_o,
    output logic [DATA_WIDTH-1:0]                  s_dat_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    output logic [DATA_WIDTH/8-1:0]                s_sel_o,
    output logic                                   s_we_o,
    output logic [2:0]                             s_cti_o,
    output logic [1:0]                             s_bte_o,
    input  logic [DATA_WIDTH-1:0]                  s_dat_i,
    input  logic                                   s_ack_i,
    input  logic                                   s_err_i,
    input  logic                                   s_rty_i,
    output logic [MASTERS-1:0]                     grant_o
);

    localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MASTERS-1:0] r_grant;
    logic [MASTERS-1:0] w_grant_nxt;
    logic [MASTERS-1:0] w_pick;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_ptr_nxt;
    logic [PW-1:0]      w_pick_ptr;
    logic               w_found;
    logic [TW-1:0]      r_cnt;
    logic [TW-1:0]      w_cnt_nxt;
    logic               r_to_err;
    logic               w_to_nxt;
    logic               w_busy;
    logic               w_resp;
    logic               w_to_hit;

    // Search order starts at ptr and wraps; the outer loop sets priority.
    always_comb begin
        w_found    = 1'b0;
        w_pick     = '0;
        w_pick_ptr = '0;
        for (int i = 0; i < MASTERS; i++) begin
            for (int k = 0; k < MASTERS; k++) begin
                if (!w_found && m_cyc_i[k] &&
                    (((int'(r_ptr) + i) % MASTERS) == k)) begin
                    w_found    = 1'b1;
                    w_pick[k]  = 1'b1;
                    w_pick_ptr = PW'((k + 1) % MASTERS);
                end
            end
        end
    end

    // Grant is all-zero in IDLE, so every slave-side output falls to 0.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (r_grant[k]) begin
                s_adr_o = m_adr_i[k];
                s_dat_o = m_dat_i[k];
                s_cyc_o = m_cyc_i[k];
                s_stb_o = m_cyc_i[k] & m_stb_i[k];
                s_sel_o = m_sel_i[k];
                s_we_o  = m_we_i[k];
                s_cti_o = m_cti_i[k];
                s_bte_o = m_bte_i[k];
            end
        end
    end

    assign w_busy   = (r_state == ST_BUSY);
    assign w_resp   = s_ack_i | s_err_i | s_rty_i | r_to_err;
    assign w_to_hit = (TIMEOUT != 0) && w_busy && s_stb_o && !w_resp &&
                      (r_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = '0;
        w_to_nxt    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_pick;
                    w_ptr_nxt   = w_pick_ptr;
                end
            end
            ST_BUSY: begin
                if (!s_cyc_o) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end else if (s_stb_o && !w_resp) begin
                    if (w_to_hit) begin
                        w_to_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_to_err <= w_to_nxt;
        end
    end

    assign m_dat_o = {MASTERS{s_dat_i}};
    assign m_ack_o = r_grant & {MASTERS{s_ack_i}};
    assign m_err_o = r_grant & {MASTERS{s_err_i | r_to_err}};
    assign m_rty_o = r_grant & {MASTERS{s_rty_i}};
    assign grant_o = r_grant;

endmodule

// File: tb/tb_soc_arb_wb.sv
// Directed vector bench for soc_arb_wb: two masters, TIMEOUT of 4 cycles.
module tb_soc_arb_wb;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0][31:0] m_adr;
    logic [1:0][31:0] m_dat;
    logic [1:0]       m_cyc;
    logic [1:0]       m_stb;
    logic [1:0]       m_we;
    logic [1:0][3:0]  m_sel;
    logic [1:0][2:0]  m_cti;
    logic [1:0][1:0]  m_bte;
    logic [1:0][31:0] m_dat_o;
    logic [1:0]       m_ack;
    logic [1:0]       m_err;
    logic [1:0]       m_rty;
    logic [31:0]      s_adr;
    logic [31:0]      s_dat_o;
    logic             s_cyc;
    logic             s_stb;
    logic [3:0]       s_sel;
    logic             s_we;
    logic [2:0]       s_cti;
    logic [1:0]       s_bte;
    logic [31:0]      s_dat_i;
    logic             s_ack;
    logic             s_err;
    logic             s_rty;
    logic [1:0]       grant;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    soc_arb_wb #(
        .MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cyc_i(m_cyc),
        .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_cti_i(m_cti), .m_bte_i(m_bte), .m_dat_o(m_dat_o),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_cyc_o(s_cyc),
        .s_stb_o(s_stb), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cti_o(s_cti), .s_bte_o(s_bte), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant)
    );

    // rsp = {rty, err, ack} driven by the slave this cycle
    typedef struct {
        logic [1:0] cyc, stb, we;
        logic [2:0] cti0, rsp;
        logic [1:0] gnt;
        logic       scyc, sstb, swe;
        logic [2:0] ecti;
        logic [1:0] mack, merr, mrty;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic [1:0] c, s, w, input logic [2:0] t, r,
        input logic [1:0] g, input logic sc, ss, sw,
        input logic [2:0] et, input logic [1:0] a, e, y);
        vec_t v;
        v.cyc = c; v.stb = s; v.we = w; v.cti0 = t; v.rsp = r;
        v.gnt = g; v.scyc = sc; v.sstb = ss; v.swe = sw;
        v.ecti = et; v.mack = a; v.merr = e; v.mrty = y;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input int id, input vec_t v);
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        logic [1:0]  eb;
        string       p;
        m_cyc = v.cyc; m_stb = v.stb; m_we = v.we; m_cti[0] = v.cti0;
        s_ack = v.rsp[0]; s_err = v.rsp[1]; s_rty = v.rsp[2];
        case (v.gnt)
            2'b01: begin ea = 32'h100; ed = 32'hA0A0A0A0; es = 4'h3; eb = 2'b01; end
            2'b10: begin ea = 32'h200; ed = 32'hDEADBEEF; es = 4'hF; eb = 2'b10; end
            default: begin ea = '0; ed = '0; es = '0; eb = '0; end
        endcase
        @(negedge clk);
        p = $sformatf("%s%0d", tag, id);
        chk({p, " grant"}, 64'(grant), 64'(v.gnt));
        chk({p, " s_cyc"}, 64'(s_cyc), 64'(v.scyc));
        chk({p, " s_stb"}, 64'(s_stb), 64'(v.sstb));
        chk({p, " s_we"},  64'(s_we),  64'(v.swe));
        chk({p, " s_cti"}, 64'(s_cti), 64'(v.ecti));
        chk({p, " m_ack"}, 64'(m_ack), 64'(v.mack));
        chk({p, " m_err"}, 64'(m_err), 64'(v.merr));
        chk({p, " m_rty"}, 64'(m_rty), 64'(v.mrty));
        chk({p, " s_adr"}, 64'(s_adr), 64'(ea));
        chk({p, " s_dat"}, 64'(s_dat_o), 64'(ed));
        chk({p, " s_sel"}, 64'(s_sel), 64'(es));
        chk({p, " s_bte"}, 64'(s_bte), 64'(eb));
        chk({p, " m_dat0"}, 64'(m_dat_o[0]), 64'h12345678);
        chk({p, " m_dat1"}, 64'(m_dat_o[1]), 64'h12345678);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_adr[0] = 32'h100;      m_adr[1] = 32'h200;
        m_dat[0] = 32'hA0A0A0A0; m_dat[1] = 32'hDEADBEEF;
        m_sel[0] = 4'h3;         m_sel[1] = 4'hF;
        m_bte[0] = 2'b01;        m_bte[1] = 2'b10;
        m_cti = '0; m_we = '0;
        m_cyc = 2'b11; m_stb = 2'b11;
        s_dat_i = 32'h12345678;
        s_ack = 1'b1; s_err = 1'b0; s_rty = 1'b0;

        // requests and a slave ack present while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst grant", 64'(grant), 64'd0);
        chk("rst s_cyc", 64'(s_cyc), 64'd0);
        chk("rst s_stb", 64'(s_stb), 64'd0);
        chk("rst m_ack", 64'(m_ack), 64'd0);
        chk("rst m_err", 64'(m_err), 64'd0);
        s_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // both masters request, one acked read each, then m0 with a slave error
        tv.push_back(mk(2'b11,2'b11,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b11,2'b11,2'b00,3'd0,3'b001, 2'b01,1'b1,1'b1,1'b0,3'd0,2'b01,2'b00,2'b00));
        tv.push_back(mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b01,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b10,2'b10,2'b00,3'd0,3'b001, 2'b10,1'b1,1'b1,1'b0,3'd0,2'b10,2'b00,2'b00));
        tv.push_back(mk(2'b01,2'b01,2'b00,3'd0,3'b000, 2'b10,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b01,2'b01,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b01,2'b01,2'b00,3'd0,3'b010, 2'b01,1'b1,1'b1,1'b0,3'd0,2'b00,2'b01,2'b00));
        tv.push_back(mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b01,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        // write 0xDEADBEEF from m1
        tv.push_back(mk(2'b10,2'b10,2'b10,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b10,2'b10,2'b10,3'd0,3'b001, 2'b10,1'b1,1'b1,1'b1,3'd0,2'b10,2'b00,2'b00));
        tv.push_back(mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b10,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        // m0 4-beat burst with an stb gap while m1 waits, then m1 gets a retry
        tv.push_back(mk(2'b11,2'b11,2'b00,3'd2,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b11,2'b11,2'b00,3'd2,3'b001, 2'b01,1'b1,1'b1,1'b0,3'd2,2'b01,2'b00,2'b00));
        tv.push_back(mk(2'b11,2'b10,2'b00,3'd2,3'b000, 2'b01,1'b1,1'b0,1'b0,3'd2,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b11,2'b11,2'b00,3'd2,3'b001, 2'b01,1'b1,1'b1,1'b0,3'd2,2'b01,2'b00,2'b00));
        tv.push_back(mk(2'b11,2'b11,2'b00,3'd2,3'b001, 2'b01,1'b1,1'b1,1'b0,3'd2,2'b01,2'b00,2'b00));
        tv.push_back(mk(2'b11,2'b11,2'b00,3'd7,3'b001, 2'b01,1'b1,1'b1,1'b0,3'd7,2'b01,2'b00,2'b00));
        tv.push_back(mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b01,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b10,2'b10,2'b00,3'd0,3'b100, 2'b10,1'b1,1'b1,1'b0,3'd0,2'b00,2'b00,2'b10));
        tv.push_back(mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b10,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        tv.push_back(mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));

        foreach (tv[i]) run_vec("v", i, tv[i]);

        // silent slave: stb rises in cycle 1, timeout error in cycle 5 only
        run_vec("to", 0, mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        for (int i = 1; i <= 4; i++)
            run_vec("to", i, mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b10,1'b1,1'b1,1'b0,3'd0,2'b00,2'b00,2'b00));
        run_vec("to", 5, mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b10,1'b1,1'b1,1'b0,3'd0,2'b00,2'b10,2'b00));
        run_vec("to", 6, mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b10,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        run_vec("to", 7, mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));

        // ack in the 4th stb cycle beats the timeout
        run_vec("ak", 0, mk(2'b01,2'b01,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        for (int i = 1; i <= 3; i++)
            run_vec("ak", i, mk(2'b01,2'b01,2'b00,3'd0,3'b000, 2'b01,1'b1,1'b1,1'b0,3'd0,2'b00,2'b00,2'b00));
        run_vec("ak", 4, mk(2'b01,2'b01,2'b00,3'd0,3'b001, 2'b01,1'b1,1'b1,1'b0,3'd0,2'b01,2'b00,2'b00));
        run_vec("ak", 5, mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b01,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        run_vec("ak", 6, mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));

        // reset pulse while m1 owns with stb high
        run_vec("rs", 0, mk(2'b10,2'b10,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        #2;
        chk("rs own grant", 64'(grant), 64'(2'b10));
        chk("rs own s_stb", 64'(s_stb), 64'd1);
        rst_n = 1'b0;
        s_ack = 1'b1;
        #1;
        chk("rs mid grant", 64'(grant), 64'd0);
        chk("rs mid s_cyc", 64'(s_cyc), 64'd0);
        chk("rs mid s_stb", 64'(s_stb), 64'd0);
        chk("rs mid m_ack", 64'(m_ack), 64'd0);
        chk("rs mid m_err", 64'(m_err), 64'd0);
        @(posedge clk);
        #1;
        s_ack = 1'b0;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        rst_n = 1'b1;
        run_vec("rs", 1, mk(2'b11,2'b11,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        run_vec("rs", 2, mk(2'b11,2'b11,2'b00,3'd0,3'b001, 2'b01,1'b1,1'b1,1'b0,3'd0,2'b01,2'b00,2'b00));
        run_vec("rs", 3, mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b01,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));
        run_vec("rs", 4, mk(2'b00,2'b00,2'b00,3'd0,3'b000, 2'b00,1'b0,1'b0,1'b0,3'd0,2'b00,2'b00,2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_arb_wb.md
SOC_ARB_WB -- requirements
Module: soc_arb_wb

Interface
REQ-001 SHALL have parameter MASTERS, default 2: number of Wishbone masters, 1..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width in bits, multiple of 8; SEL_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width in bits.
REQ-004 SHALL have parameter TIMEOUT, default 256: cycles without a slave response before an error is generated; 0 disables the timeout.
REQ-005 SHALL have one clock and an asynchronous, active-low reset:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-low
REQ-006 SHALL have master-side ports, each indexed per master:
- m_adr_i  in  [MASTERS][ADDR_WIDTH]  address
- m_dat_i  in  [MASTERS][DATA_WIDTH]  write data
- m_cyc_i, m_stb_i, m_we_i  in  [MASTERS]  cycle, strobe, write enable
- m_sel_i  in  [MASTERS][SEL_WIDTH]  byte select
- m_cti_i  in  [MASTERS][3]  cycle type
- m_bte_i  in  [MASTERS][2]  burst type
- m_dat_o  out  [MASTERS][DATA_WIDTH]  read data
- m_ack_o, m_err_o, m_rty_o  out  [MASTERS]  responses
REQ-007 SHALL have slave-side ports for a single slave:
- s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_sel_o, s_we_o, s_cti_o, s_bte_o  out  same widths as the master-side ports, unindexed
- s_dat_i  in  DATA_WIDTH  read data
- s_ack_i, s_err_i, s_rty_i  in  1  responses
REQ-008 SHALL have grant_o  out  [MASTERS]  one-hot current owner, all-zero when idle.

Function
REQ-009 SHALL implement a two-state FSM (IDLE, BUSY) with a one-hot grant register and a round-robin pointer ptr.
REQ-010 In IDLE, SHALL select the first master k with m_cyc_i[k]=1, searching from ptr upward modulo MASTERS.
REQ-011 On the rising edge after a request is seen in IDLE, SHALL load grant with k, set ptr=(k+1) mod MASTERS, and enter BUSY; arbitration latency is 1 cycle.
REQ-012 In IDLE, SHALL hold grant_o=0 and s_cyc_o=s_stb_o=0, and drive all other s_* outputs to 0.
REQ-013 In BUSY, SHALL drive all s_* outputs combinationally from the granted master.
REQ-014 SHALL route s_ack_i, s_err_i and s_rty_i only to the granted master; all other masters see 0.
REQ-015 SHALL broadcast s_dat_i to every m_dat_o.
REQ-016 SHALL keep ownership while the granted m_cyc_i stays high, including across stb gaps and bursts (cti 001/010).
- Other requests SHALL NOT pre-empt the owner.
REQ-017 When the granted m_cyc_i goes low, s_cyc_o SHALL drop the same cycle, and the FSM SHALL return to IDLE on the next edge.
- Minimum gap between owners is 1 idle cycle.
REQ-018 In BUSY, SHALL count cycles with s_stb_o=1 and no ack, err or rty; the counter clears on any response, on stb low, and on entering IDLE.
REQ-019 When TIMEOUT>0 and the counter reaches TIMEOUT-1, SHALL assert m_err_o of the owner for exactly 1 cycle, then clear the counter.
REQ-020 If a slave response and the timeout fall in the same cycle, the slave response SHALL win and no timeout error SHALL be generated.
REQ-021 With MASTERS=1, SHALL behave identically, with ptr fixed at 0.
REQ-022 A master that drops m_cyc_i while waiting SHALL lose its request; no request is queued.

Reset
REQ-023 While rst_i=0, asynchronously:
- FSM=IDLE, grant=0, ptr=0, timeout counter=0
- all m_ack_o, m_err_o, m_rty_o=0; s_cyc_o=s_stb_o=0
REQ-024 Reset asserted mid-transfer SHALL abort the transfer immediately, with no response delivered; after release, arbitration restarts from master 0.

Verification
REQ-025 With MASTERS=2, m_cyc_i=2'b11 from reset release, each master releasing after one acked single read:
- grant_o sequence 01, idle, 10, idle, 01.
REQ-026 m0 runs a 4-beat incrementing burst (cti 010 then 111) while m1 requests:
- grant stays 01 for all 4 acks.
- m1 is granted 2 cycles after m0 drops cyc.
REQ-027 With TIMEOUT=4, slave never responds to m1:
- m_err_o[1] pulses 1 cycle, exactly 4 cycles after s_stb_o rises.
- m_ack_o stays 0 on both masters.
REQ-028 With TIMEOUT=4, s_ack_i arrives in the 4th stb cycle:
- m_ack_o[owner]=1 and m_err_o=0.
REQ-029 rst_i pulsed low while m1 owns and s_stb_o=1:
- s_cyc_o=0 and grant_o=0 immediately.
- After release, with both masters requesting, m0 is granted first.
REQ-030 A write of 0xDEADBEEF with sel=4'hF from m1:
- s_dat_o=0xDEADBEEF and s_we_o=1 on the granted cycle.
- s_dat_i=0x12345678 appears on both m_dat_o, with m_ack_o=2'b10.
